bus_arbiter_2x1: RTL and testbench

- Two-requester round-robin arbiter that shares one memory/bus port between requester 0 (e.g. instruction fetch) and requester 1 (e.g. data load/store).
- Owns the select line of a 32-bit 2x1 mux that steers address, write data and write enable onto the shared port.
- Forwards the port's completion strobe back to the granted requester only.
- Sits between the processor control unit and the memory model.

---
 rtl/bus_arbiter_2x1_pkg.sv | 31 +++
 rtl/mux32_2x1.sv | 15 +
 rtl/bus_arbiter_2x1.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter_2x1.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_2x1_pkg.sv
// Shared definitions for the two-requester round-robin bus arbiter:
// state encodings, default widths and the round-robin pick function.
package bus_arbiter_2x1_pkg;

  localparam int unsigned PROJ_DATA_W  = 32;
  localparam int unsigned DATA_W_DEF   = PROJ_DATA_W;
  localparam int unsigned MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_G0   = 2'b01,
    ARB_G1   = 2'b10
  } arb_state_e;

  // Round-robin pick: on a tie the requester that did not complete last wins.
  function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                          input logic last);
    arb_state_e pick;
    if (req0 && req1) begin
      pick = last ? ARB_G0 : ARB_G1;
    end else if (req0) begin
      pick = ARB_G0;
    end else if (req1) begin
      pick = ARB_G1;
    end else begin
      pick = ARB_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux32_2x1.sv
// Width-parameterised 2:1 mux steering one requester's payload onto the shared port.
module mux32_2x1
  import bus_arbiter_2x1_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEF
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/bus_arbiter_2x1.sv
// Round-robin arbiter sharing one bus port between two requesters.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD grant-hold timeout.
module bus_arbiter_2x1
  import bus_arbiter_2x1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  input  logic              WE0,
  input  logic              WE1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DONE0,
  output logic              DONE1,
  output logic              SEL,
  output logic              BUS_REQ,
  output logic [DATA_W-1:0] BUS_ADDR,
  output logic [DATA_W-1:0] BUS_WDATA,
  output logic              BUS_WE,
  input  logic              BUS_DONE,
  output logic              TIMEOUT
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt1_q, sel_q, breq_q;
  logic       own, own_req;
  logic       we_sel;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              hold_c;
`endif

  // Next-state: arbitrate from IDLE, or on completion / abandon / timeout of a grant.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own     = (state_q == ARB_G1);
    own_req = own ? REQ1 : REQ0;
    case (state_q)
      ARB_IDLE: state_d = arb_pick(REQ0, REQ1, last_q);
      ARB_G0, ARB_G1: begin
        if (BUS_DONE) begin
          last_d  = own;
          state_d = arb_pick(REQ0, REQ1, own);
        end else if (!own_req) begin
          state_d = arb_pick(REQ0, REQ1, last_q);
`ifdef ARB_TIMEOUT_EN
        end else if (timeout_q) begin
          last_d  = own;
          state_d = arb_pick(REQ0, REQ1, own);
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
      breq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0_q  <= (state_d == ARB_G0);
      gnt1_q  <= (state_d == ARB_G1);
      sel_q   <= (state_d == ARB_G1);
      breq_q  <= (state_d != ARB_IDLE);
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Counter restarts on every grant entry; TIMEOUT lands on the MAX_HOLD-th held cycle.
  assign hold_c    = (state_q != ARB_IDLE) && !(BUS_DONE || !own_req || timeout_q);
  assign cnt_d     = hold_c ? cnt_q + HOLD_W'(1) : '0;
  assign timeout_d = hold_c && (cnt_d == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  mux32_2x1 #(.W(DATA_W)) u_addr_mux (
    .sel_i (sel_q),
    .a_i   (ADDR0),
    .b_i   (ADDR1),
    .y_o   (BUS_ADDR)
  );

  mux32_2x1 #(.W(DATA_W)) u_wdata_mux (
    .sel_i (sel_q),
    .a_i   (WDATA0),
    .b_i   (WDATA1),
    .y_o   (BUS_WDATA)
  );

  mux32_2x1 #(.W(1)) u_we_mux (
    .sel_i (sel_q),
    .a_i   (WE0),
    .b_i   (WE1),
    .y_o   (we_sel)
  );

  assign GNT0    = gnt0_q;
  assign GNT1    = gnt1_q;
  assign SEL     = sel_q;
  assign BUS_REQ = breq_q;
  assign BUS_WE  = we_sel & breq_q;
  assign DONE0   = BUS_DONE & gnt0_q;
  assign DONE1   = BUS_DONE & gnt1_q;

endmodule

// File: tb/tb_bus_arbiter_2x1.sv
// Scoreboard bench for bus_arbiter_2x1: per-cycle stimulus tables, expected
// port values queued at drive time and popped when the outputs are sampled.
module tb_bus_arbiter_2x1;

  localparam int unsigned W = 32;
  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_0 = 2'b01;
  localparam logic [1:0] S_1 = 2'b10;
  localparam logic [W-1:0] A0 = 32'h0000_0100;
  localparam logic [W-1:0] A1 = 32'h0000_0200;
  localparam logic [W-1:0] D0 = 32'hAAAA_0000;
  localparam logic [W-1:0] D1 = 32'h5555_FFFF;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         REQ0 = 1'b0, REQ1 = 1'b0;
  logic [W-1:0] ADDR0 = A0, ADDR1 = A1, WDATA0 = D0, WDATA1 = D1;
  logic         WE0 = 1'b0, WE1 = 1'b0;
  logic         GNT0, GNT1, DONE0, DONE1, SEL, BUS_REQ, BUS_WE, TIMEOUT;
  logic [W-1:0] BUS_ADDR, BUS_WDATA;
  logic         BUS_DONE = 1'b0;

  typedef struct packed {
    logic         g0, g1, sel, breq, we, to, d0, d1;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

`ifdef ARB_TIMEOUT_EN
  bus_arbiter_2x1 #(.DATA_W(W), .MAX_HOLD(4)) dut (
`else
  bus_arbiter_2x1 #(.DATA_W(W)) dut (
`endif
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .WE0(WE0), .WE1(WE1), .GNT0(GNT0), .GNT1(GNT1),
    .DONE0(DONE0), .DONE1(DONE1), .SEL(SEL), .BUS_REQ(BUS_REQ),
    .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_WE(BUS_WE),
    .BUS_DONE(BUS_DONE), .TIMEOUT(TIMEOUT)
  );

  // Expected port picture for a given grant state and {done0,done1,timeout} flags.
  function automatic exp_t mk(input logic [1:0] s, input logic [2:0] f);
    exp_t e;
    e.g0    = (s == S_0);
    e.g1    = (s == S_1);
    e.sel   = e.g1;
    e.breq  = e.g0 | e.g1;
    e.we    = e.breq & (e.g1 ? WE1 : WE0);
    e.d0    = f[2];
    e.d1    = f[1];
    e.to    = f[0];
    e.addr  = e.g1 ? A1 : A0;
    e.wdata = e.g1 ? D1 : D0;
    return e;
  endfunction

  function automatic exp_t obs();
    return {GNT0, GNT1, SEL, BUS_REQ, BUS_WE, TIMEOUT, DONE0, DONE1, BUS_ADDR, BUS_WDATA};
  endfunction

  task automatic do_reset();
    {REQ0, REQ1, WE0, WE1, BUS_DONE} = 5'b0;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    RST = 1'b0;
    {REQ0, REQ1, WE0, WE1, BUS_DONE} = 5'b11101;
    repeat (2) @(posedge CLK);
    #1;
    sb.push_back(mk(S_I, 3'b000));
    e = sb.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL reset: got %h exp %h", o, e);
    end
    {REQ0, REQ1, WE0, WE1, BUS_DONE} = 5'b0;
    RST = 1'b1;
  endtask

  task automatic test_single();
    logic [4:0] st[$];
    logic [1:0] es[$];
    logic [2:0] ef[$];
    exp_t e, o;
    st = '{5'b10000, 5'b10000, 5'b00001, 5'b00000, 5'b00001, 5'b00000};
    es = '{S_I, S_0, S_0, S_I, S_I, S_I};
    ef = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < st.size(); i++) begin
      {REQ0, REQ1, WE0, WE1, BUS_DONE} = st[i];
      sb.push_back(mk(es[i], ef[i]));
      #1;
      e = sb.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL single c%0d: got %h exp %h", i, o, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] st[$];
    logic [1:0] es[$];
    logic [2:0] ef[$];
    exp_t e, o;
    st = '{5'b11010, 5'b11010, 5'b11011, 5'b11010, 5'b11011,
           5'b11010, 5'b11011, 5'b11010, 5'b00011, 5'b00010};
    es = '{S_I, S_0, S_0, S_1, S_1, S_0, S_0, S_1, S_1, S_I};
    ef = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b010,
           3'b000, 3'b100, 3'b000, 3'b010, 3'b000};
    for (int i = 0; i < st.size(); i++) begin
      {REQ0, REQ1, WE0, WE1, BUS_DONE} = st[i];
      sb.push_back(mk(es[i], ef[i]));
      #1;
      e = sb.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL back_to_back c%0d: got %h exp %h", i, o, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  // Abandons release the grant without touching the round-robin pointer.
  task automatic test_abandon();
    logic [4:0] st[$];
    logic [1:0] es[$];
    logic [2:0] ef[$];
    exp_t e, o;
    st = '{5'b10000, 5'b10000, 5'b00001, 5'b01000, 5'b01000, 5'b00000,
           5'b00000, 5'b11000, 5'b10000, 5'b10000, 5'b00001, 5'b00000};
    es = '{S_I, S_0, S_0, S_I, S_1, S_1, S_I, S_I, S_1, S_0, S_0, S_I};
    ef = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000,
           3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
    for (int i = 0; i < st.size(); i++) begin
      {REQ0, REQ1, WE0, WE1, BUS_DONE} = st[i];
      sb.push_back(mk(es[i], ef[i]));
      #1;
      e = sb.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL abandon c%0d: got %h exp %h", i, o, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_hold();
    logic [4:0] st[$];
    logic [1:0] es[$];
    logic [2:0] ef[$];
    exp_t e, o;
    st.push_back(5'b10000); es.push_back(S_I); ef.push_back(3'b000);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      st.push_back(5'b10000); es.push_back(S_0); ef.push_back(3'b000);
    end
    st.push_back(5'b11000); es.push_back(S_0); ef.push_back(3'b001);
    st.push_back(5'b00001); es.push_back(S_1); ef.push_back(3'b010);
`else
    for (int k = 0; k < 20; k++) begin
      st.push_back(5'b10000); es.push_back(S_0); ef.push_back(3'b000);
    end
    st.push_back(5'b00001); es.push_back(S_0); ef.push_back(3'b100);
`endif
    st.push_back(5'b00000); es.push_back(S_I); ef.push_back(3'b000);
    for (int i = 0; i < st.size(); i++) begin
      {REQ0, REQ1, WE0, WE1, BUS_DONE} = st[i];
      sb.push_back(mk(es[i], ef[i]));
      #1;
      e = sb.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL hold c%0d: got %h exp %h", i, o, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] st[$];
    logic [1:0] es[$];
    logic [2:0] ef[$];
    exp_t e, o;
    st = '{5'b01010, 5'b01010};
    es = '{S_I, S_1};
    ef = '{3'b000, 3'b000};
    for (int i = 0; i < st.size(); i++) begin
      {REQ0, REQ1, WE0, WE1, BUS_DONE} = st[i];
      sb.push_back(mk(es[i], ef[i]));
      #1;
      e = sb.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL reset_mid pre c%0d: got %h exp %h", i, o, e);
      end
      if (i == 0) begin
        @(posedge CLK); #1;
      end
    end
    #2;
    RST = 1'b0;
    sb.push_back(mk(S_I, 3'b000));
    #1;
    e = sb.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin
      n_fail++; $display("FAIL reset_mid drop: got %h exp %h", o, e);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    st = '{5'b11000, 5'b11000, 5'b00001, 5'b00000};
    es = '{S_I, S_0, S_0, S_I};
    ef = '{3'b000, 3'b000, 3'b100, 3'b000};
    for (int i = 0; i < st.size(); i++) begin
      {REQ0, REQ1, WE0, WE1, BUS_DONE} = st[i];
      sb.push_back(mk(es[i], ef[i]));
      #1;
      e = sb.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL reset_mid post c%0d: got %h exp %h", i, o, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_single();
    do_reset();
    test_back_to_back();
    test_abandon();
    test_hold();
    do_reset();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
